// File: rtl/rename_pkg.sv
// Shared types for the rename-stage allocation controller: dispatch width,
// slot-count type and the allocation FSM states.
package rename_pkg;

  localparam int WAYS      = 4;
  localparam int PRF_IDX_W = 7;
  localparam int CNT_BITS  = $clog2(WAYS + 1);

  typedef logic [CNT_BITS-1:0] cnt_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } alloc_state_e;

  // Upstream counts may exceed WAYS; anything larger is no more useful than WAYS.
  function automatic cnt_t clamp_cnt(input cnt_t v);
    return (v > cnt_t'(WAYS)) ? cnt_t'(WAYS) : v;
  endfunction

endpackage

// File: rtl/rename_alloc_ctrl_prefix_grant.sv
// Combinational in-order grant: the longest prefix of valid slots that fits
// within ROB space, RS space and free-list PRF availability.
module prefix_grant
  import rename_pkg::*;
(
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] dest,
  input  cnt_t            fl_lim,
  input  cnt_t            rob_lim,
  input  cnt_t            rs_lim,
  output logic [WAYS-1:0] grant
);

  cnt_t need;
  logic run;

  // run drops at the first failing slot and stays low, so grant is always a prefix.
  always_comb begin
    grant = '0;
    need  = '0;
    run   = 1'b1;
    for (int i = 0; i < WAYS; i++) begin
      need     = need + cnt_t'(dest[i] & valid[i]);
      run      = run & valid[i] & (cnt_t'(i + 1) <= rob_lim) &
                 (cnt_t'(i + 1) <= rs_lim) & (need <= fl_lim);
      grant[i] = run;
    end
  end

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename dispatch allocation controller: per-cycle grant, post-exception recovery
// window and starvation flag. Define RENAME_STALL_STATS_EN to add stall counters.
module rename_alloc_ctrl
  import rename_pkg::*;
#(
  parameter int RECOVER_CYCLES = 2,
  parameter int STARVE_LIMIT   = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             except,
  input  logic [WAYS-1:0]  disp_valid,
  input  logic [WAYS-1:0]  disp_dest,
  input  cnt_t             fl_avail,
  input  cnt_t             rob_free,
  input  cnt_t             rs_free,
  output logic [WAYS-1:0]  fl_needed,
  output logic [WAYS-1:0]  disp_grant,
  output logic             stall,
  output logic             recovering,
  output logic             starve
`ifdef RENAME_STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_fl_stall,
  output logic [CNT_W-1:0] stat_rob_stall,
  output logic [CNT_W-1:0] stat_rs_stall,
  output logic [CNT_W-1:0] stat_recover
`endif
);

  localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RECOVER_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);

  alloc_state_e    state, state_nxt;
  logic [RC_W-1:0] recover_cnt, recover_cnt_nxt;
  logic [SC_W-1:0] starve_cnt, starve_cnt_nxt;
  cnt_t            fl_c, rob_c, rs_c;
  logic [WAYS-1:0] grant_raw;

  assign fl_c  = clamp_cnt(fl_avail);
  assign rob_c = clamp_cnt(rob_free);
  assign rs_c  = clamp_cnt(rs_free);

  prefix_grant u_prefix_grant (
    .valid   (disp_valid),
    .dest    (disp_dest),
    .fl_lim  (fl_c),
    .rob_lim (rob_c),
    .rs_lim  (rs_c),
    .grant   (grant_raw)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      recover_cnt <= '0;
      starve_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      recover_cnt <= recover_cnt_nxt;
      starve_cnt  <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    recover_cnt_nxt = recover_cnt;
    starve_cnt_nxt  = starve_cnt;
    disp_grant      = '0;
    recovering      = 1'b0;

    case (state)
      RUN:     if (!except) disp_grant = grant_raw;
      RECOVER: recovering = 1'b1;
      default: disp_grant = '0;
    endcase

    // except wins over everything, including re-arming an active window.
    if (except) begin
      state_nxt       = RECOVER;
      recover_cnt_nxt = RC_INIT;
    end else if (state == RECOVER) begin
      if (recover_cnt == '0) state_nxt = RUN;
      else                   recover_cnt_nxt = recover_cnt - 1'b1;
    end

    if (except || (disp_valid == '0) || (disp_grant != '0))
      starve_cnt_nxt = '0;
    else if ((state == RUN) && (starve_cnt != SC_MAX))
      starve_cnt_nxt = starve_cnt + 1'b1;

    fl_needed = disp_grant & disp_dest;
    stall     = |(disp_valid & ~disp_grant);
    starve    = (starve_cnt == SC_MAX);

    // Outputs are held quiet while reset is asserted, including the combinational ones.
    if (!reset) begin
      disp_grant = '0;
      fl_needed  = '0;
      stall      = 1'b0;
      recovering = 1'b0;
      starve     = 1'b0;
    end
  end

`ifdef RENAME_STALL_STATS_EN
  logic slot0_blocked;

  assign slot0_blocked = (state == RUN) && !except && disp_valid[0] && !grant_raw[0];

  // Only the first failing cause is charged: free list, then ROB, then RS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_fl_stall  <= '0;
      stat_rob_stall <= '0;
      stat_rs_stall  <= '0;
      stat_recover   <= '0;
    end else begin
      if (slot0_blocked) begin
        if (disp_dest[0] && (fl_c == '0)) stat_fl_stall  <= stat_fl_stall + 1'b1;
        else if (rob_c == '0)             stat_rob_stall <= stat_rob_stall + 1'b1;
        else if (rs_c == '0)              stat_rs_stall  <= stat_rs_stall + 1'b1;
      end
      if (state == RECOVER) stat_recover <= stat_recover + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Scoreboard bench for rename_alloc_ctrl: directed cases plus random traffic,
// checked against a slot-counting reference model.
module tb_rename_alloc_ctrl;

  localparam int LIMIT = 64;
  localparam int RCYC  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       except = 1'b0;
  logic [3:0] disp_valid = '0, disp_dest = '0;
  logic [2:0] fl_avail = '0, rob_free = '0, rs_free = '0;
  logic [3:0] fl_needed, disp_grant;
  logic       stall, recovering, starve;
`ifdef RENAME_STALL_STATS_EN
  logic [31:0] stat_fl_stall, stat_rob_stall, stat_rs_stall, stat_recover;
`endif

  rename_alloc_ctrl #(.RECOVER_CYCLES(RCYC), .STARVE_LIMIT(LIMIT), .CNT_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .except     (except),
    .disp_valid (disp_valid),
    .disp_dest  (disp_dest),
    .fl_avail   (fl_avail),
    .rob_free   (rob_free),
    .rs_free    (rs_free),
    .fl_needed  (fl_needed),
    .disp_grant (disp_grant),
    .stall      (stall),
    .recovering (recovering),
    .starve     (starve)
`ifdef RENAME_STALL_STATS_EN
    ,
    .stat_fl_stall  (stat_fl_stall),
    .stat_rob_stall (stat_rob_stall),
    .stat_rs_stall  (stat_rs_stall),
    .stat_recover   (stat_recover)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [10:0] core;   // {grant, needed, stall, recovering, starve}
    logic [31:0] st_fl, st_rob, st_rs, st_rec;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_rec = 0;
  int m_left = 0;
  int m_starve = 0;
  int m_sfl = 0, m_srob = 0, m_srs = 0, m_srec = 0;

  function automatic int cap(input int x);
    return (x > 4) ? 4 : x;
  endfunction

  task automatic drive(input bit r, input bit ex, input logic [3:0] v, input logic [3:0] d,
                       input int fl, input int rob, input int rs, input int tag);
    exp_t e;
    int lead, k, used, g;
    logic [3:0] gr;
    @(posedge clock);
    #1;
    reset = r; except = ex; disp_valid = v; disp_dest = d;
    fl_avail = 3'(fl); rob_free = 3'(rob); rs_free = 3'(rs);

    e.tag = tag;
    if (!r) begin
      m_rec = 0; m_left = 0; m_starve = 0;
      m_sfl = 0; m_srob = 0; m_srs = 0; m_srec = 0;
      e.core = '0;
      e.st_fl = 0; e.st_rob = 0; e.st_rs = 0; e.st_rec = 0;
      exp_q.push_back(e);
      return;
    end

    // Grant = longest run of leading valid slots fitting every resource limit.
    g = 0;
    if (!ex && !m_rec) begin
      lead = 0;
      while (lead < 4 && v[lead]) lead++;
      k = lead;
      if (cap(rob) < k) k = cap(rob);
      if (cap(rs) < k) k = cap(rs);
      used = 0;
      for (int j = 0; j < k; j++) begin
        used += int'(d[j]);
        if (used > cap(fl)) break;
        g = j + 1;
      end
    end
    gr = 4'((1 << g) - 1);
    e.core = {gr, gr & d, |(v & ~gr), m_rec, (m_starve == LIMIT)};
    e.st_fl = 32'(m_sfl); e.st_rob = 32'(m_srob); e.st_rs = 32'(m_srs); e.st_rec = 32'(m_srec);
    exp_q.push_back(e);

    if (!m_rec && !ex && v[0] && g == 0) begin
      if (d[0] && cap(fl) == 0) m_sfl++;
      else if (cap(rob) == 0)   m_srob++;
      else if (cap(rs) == 0)    m_srs++;
    end
    if (m_rec) m_srec++;

    if (ex || v == 0 || g != 0) m_starve = 0;
    else if (!m_rec && m_starve < LIMIT) m_starve++;

    if (ex) begin
      m_rec = 1; m_left = RCYC - 1;
    end else if (m_rec) begin
      if (m_left == 0) m_rec = 0;
      else m_left--;
    end
  endtask

  // Monitor: compares the DUT against the oldest outstanding expectation each cycle.
  initial begin
    exp_t e;
    logic [10:0] got;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {disp_grant, fl_needed, stall, recovering, starve};
        checks++;
        if (got !== e.core) begin
          errors++;
          $display("FAIL outputs tag=%0d got grant=%b need=%b stall=%b rec=%b starve=%b exp grant=%b need=%b stall=%b rec=%b starve=%b",
                   e.tag, got[10:7], got[6:3], got[2], got[1], got[0],
                   e.core[10:7], e.core[6:3], e.core[2], e.core[1], e.core[0]);
        end
`ifdef RENAME_STALL_STATS_EN
        checks++;
        if (stat_fl_stall !== e.st_fl || stat_rob_stall !== e.st_rob ||
            stat_rs_stall !== e.st_rs || stat_recover !== e.st_rec) begin
          errors++;
          $display("FAIL stats tag=%0d got fl=%0d rob=%0d rs=%0d rec=%0d exp fl=%0d rob=%0d rs=%0d rec=%0d",
                   e.tag, stat_fl_stall, stat_rob_stall, stat_rs_stall, stat_recover,
                   e.st_fl, e.st_rob, e.st_rs, e.st_rec);
        end
`endif
      end
    end
  end

  initial begin
    logic [3:0] v;
    // reset state
    drive(0, 0, 4'b1111, 4'b1111, 4, 4, 4, 0);
    drive(0, 0, 4'b1111, 4'b1111, 4, 4, 4, 0);
    // free-list stalls charged before ROB
    for (int i = 0; i < 5; i++) drive(1, 0, 4'b0001, 4'b0001, 0, 0, 4, 6);
    drive(1, 0, 4'b0000, 4'b0000, 4, 4, 4, 6);
    // free-list limited prefix
    drive(1, 0, 4'b1111, 4'b1111, 2, 4, 4, 1);
    drive(1, 0, 4'b1111, 4'b1010, 1, 4, 4, 2);
    drive(1, 0, 4'b1011, 4'b0000, 4, 4, 4, 5);
    drive(1, 0, 4'b1111, 4'b0000, 7, 6, 5, 7);
    drive(1, 0, 4'b1111, 4'b0000, 4, 2, 3, 8);
    // single recovery window, then one extended by a second except
    drive(1, 1, 4'b1111, 4'b0000, 4, 4, 4, 3);
    for (int i = 0; i < 3; i++) drive(1, 0, 4'b1111, 4'b0000, 4, 4, 4, 3);
    drive(1, 1, 4'b1111, 4'b0000, 4, 4, 4, 31);
    drive(1, 1, 4'b1111, 4'b0000, 4, 4, 4, 31);
    for (int i = 0; i < 4; i++) drive(1, 0, 4'b1111, 4'b0000, 4, 4, 4, 31);
    // starvation build-up and release
    drive(1, 0, 4'b0000, 4'b0000, 4, 4, 4, 4);
    for (int i = 0; i < LIMIT + 2; i++) drive(1, 0, 4'b0001, 4'b0000, 4, 0, 4, 4);
    drive(1, 0, 4'b0001, 4'b0000, 4, 1, 4, 4);
    drive(1, 0, 4'b0001, 4'b0000, 4, 1, 4, 4);
    // reset in the middle of a recovery window
    drive(1, 1, 4'b1111, 4'b0000, 4, 4, 4, 9);
    drive(0, 0, 4'b1111, 4'b0000, 4, 4, 4, 9);
    drive(1, 0, 4'b1111, 4'b0000, 4, 4, 4, 9);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) < 6) v = 4'((1 << $urandom_range(0, 4)) - 1);
      else                          v = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0), v,
            4'($urandom_range(0, 15)), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 7),
            $urandom_range(0, 7), 100);
    end
    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
